// File: rtl/approx_add_pipe.sv
// =============================================================================
// approx_add_pipe : lower-part-OR approximate adder, valid pipeline with stall,
//                   exact shadow sum for error reporting and error statistics.
// Revision 1.0
// =============================================================================
`default_nettype none

module approx_add_pipe #(
    parameter int WIDTH  = 8,
    parameter int KMAX   = 4,
    parameter int STAGES = 2,
    parameter int KW     = $clog2(KMAX + 1) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [KW-1:0]    i_k,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH:0]   o_o,
    output logic [WIDTH:0]   o_err,
    input  logic             i_stat_clr,
    output logic [15:0]      o_err_cnt,
    output logic [WIDTH:0]   o_err_max
);

    localparam int            C_W1   = WIDTH + 1;
    localparam logic [KW-1:0] C_KMAX = KW'(KMAX);

    logic              w_en;
    logic [KW-1:0]     w_k_eff;
    logic [KW-1:0]     w_k_idx;
    logic [C_W1-1:0]   w_a_ext;
    logic [C_W1-1:0]   w_b_ext;
    logic [C_W1-1:0]   w_mask;
    logic              w_cin;
    logic [C_W1-1:0]   w_hi;
    logic [C_W1-1:0]   w_o;
    logic [C_W1-1:0]   w_exact;
    logic              w_hs;
    logic              w_err_nz;

    logic              r_vld [STAGES];
    logic [C_W1-1:0]   r_o   [STAGES];
    logic [C_W1-1:0]   r_ex  [STAGES];
    logic [15:0]       r_cnt;
    logic [C_W1-1:0]   r_max;

    // Single global advance: the whole pipe moves or the whole pipe freezes.
    assign w_en        = !r_vld[STAGES-1] || i_out_ready;
    assign o_in_ready  = w_en;
    assign o_out_valid = r_vld[STAGES-1];

    assign w_k_eff = (i_k > C_KMAX) ? C_KMAX : i_k;
    assign w_k_idx = w_k_eff - KW'(1);
    assign w_a_ext = {1'b0, i_a};
    assign w_b_ext = {1'b0, i_b};
    assign w_mask  = (C_W1'(1) << w_k_eff) - C_W1'(1);

    // Carry into the exact upper part is speculated from the top approximated bit.
    assign w_cin   = (w_k_eff != '0) && (|((w_a_ext & w_b_ext) & (C_W1'(1) << w_k_idx)));
    assign w_hi    = ((w_a_ext >> w_k_eff) + (w_b_ext >> w_k_eff) + C_W1'(w_cin)) << w_k_eff;
    assign w_o     = w_hi | ((w_a_ext | w_b_ext) & w_mask);
    assign w_exact = w_a_ext + w_b_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                r_vld[s] <= 1'b0;
                r_o[s]   <= '0;
                r_ex[s]  <= '0;
            end
        end else if (w_en) begin
            r_vld[0] <= i_in_valid;
            if (i_in_valid) begin
                r_o[0]  <= w_o;
                r_ex[0] <= w_exact;
            end
            for (int s = 1; s < STAGES; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_o[s]   <= r_o[s-1];
                r_ex[s]  <= r_ex[s-1];
            end
        end
    end

    assign o_o   = r_o[STAGES-1];
    assign o_err = (r_ex[STAGES-1] >= r_o[STAGES-1]) ? (r_ex[STAGES-1] - r_o[STAGES-1])
                                                     : (r_o[STAGES-1] - r_ex[STAGES-1]);

    assign w_hs     = r_vld[STAGES-1] && i_out_ready;
    assign w_err_nz = (o_err != '0);

    // A clear coincident with a handshake restarts the statistics from that beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_max <= '0;
        end else if (i_stat_clr) begin
            r_cnt <= (w_hs && w_err_nz) ? 16'd1 : 16'd0;
            r_max <= w_hs ? o_err : '0;
        end else if (w_hs) begin
            if (w_err_nz && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (o_err > r_max) begin
                r_max <= o_err;
            end
        end
    end

    assign o_err_cnt = r_cnt;
    assign o_err_max = r_max;

endmodule

`default_nettype wire
